mont_mul_serial: RTL

- Bit-serial Montgomery modular multiplier: R = A*B*2^(-WIDTH) mod M.
- Datapath stage feeding the ciphertext/result register. R_o drives that register's R_i; done drives its load. Shares the same ena gating.
- The exponentiation controller starts one multiplication at a time and waits for done.

---
 rtl/mont_mul_serial.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mont_mul_serial.sv
// Bit-serial Montgomery multiplier: R = A*B*2^(-WIDTH) mod M, one bit of A per enabled clock.
// Optional even-modulus rejection is compiled in with `define MONT_MUL_ODD_CHECK_EN.
module mont_mul_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic [WIDTH-1:0] M_i,
   output logic [WIDTH-1:0] R_o,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int SW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_CORR = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    s_q, s_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   logic             q_bit_s;
   logic [SW-1:0]    b_ext_s;
   logic [SW-1:0]    m_ext_s;
   logic [SW-1:0]    sum_s;
   logic             accept_s;

   // One Montgomery step; a_q is shifted right so bit 0 is always the current bit of A.
   always_comb begin
      b_ext_s = {2'b00, b_q};
      m_ext_s = {2'b00, m_q};
      q_bit_s = s_q[0] ^ (a_q[0] & b_q[0]);
      sum_s   = s_q + (a_q[0] ? b_ext_s : {SW{1'b0}}) + (q_bit_s ? m_ext_s : {SW{1'b0}});
   end

   // Start acceptance, gated by the odd-modulus check when it is compiled in.
   always_comb begin
`ifdef MONT_MUL_ODD_CHECK_EN
      accept_s = start & M_i[0];
`else
      accept_s = start;
`endif
   end

   // Next-state and datapath updates; everything holds while ena is low.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      r_d     = r_q;
      done_d  = done_q;
      err_d   = err_q;
      if (ena) begin
         case (state_q)
            ST_IDLE: begin
               done_d = 1'b0;
               if (accept_s) begin
                  a_d     = A_i;
                  b_d     = B_i;
                  m_d     = M_i;
                  s_d     = {SW{1'b0}};
                  cnt_d   = {CW{1'b0}};
                  err_d   = 1'b0;
                  state_d = ST_ITER;
               end else if (start) begin
                  // Only reachable with the odd check: even modulus is rejected in place.
                  r_d    = {WIDTH{1'b0}};
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ITER: begin
               s_d = sum_s >> 1;
               a_d = a_q >> 1;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = {CW{1'b0}};
                  state_d = ST_CORR;
               end else begin
                  cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_CORR: begin
               // S < 2M here, so one conditional subtraction lands in [0, M).
               if (s_q >= m_ext_s) begin
                  r_d = s_q[WIDTH-1:0] - m_q;
               end else begin
                  r_d = s_q[WIDTH-1:0];
               end
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         done_d = done_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CW{1'b0}};
         s_q     <= {SW{1'b0}};
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         m_q     <= {WIDTH{1'b0}};
         r_q     <= {WIDTH{1'b0}};
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         r_q     <= r_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign R_o  = r_q;
   assign done = done_q;
   assign busy = busy_q;
   assign err  = err_q;

endmodule
